shift_seq8: RTL and testbench

- Upstream command sequencer for the 8-bit registered shifter (op/shamt/d_in interface; op 111 LOAD, 001 LSL, 010 LSR, 100 ASR, 000 hold).
- Accepts one shift request with a total amount of 0..8 and splits it into LOAD plus shift steps of at most 3 bits each.
- Reads the shifter's d_out back and returns the final value with a one-cycle done pulse.
- At top level, shifter reset_n = ~reset.

---
 rtl/shift_seq8_if.sv | 25 ++
 rtl/shift_seq8.sv | 127 ++++++++++++
 tb/tb_shift_seq8.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/shift_seq8_if.sv
// Bundle of request, shifter-control and result signals between shift_seq8
// and its environment (requester plus the 8-bit registered shifter).
interface shift_seq8_if;
  logic       start;
  logic [1:0] mode;
  logic [3:0] amount;
  logic [7:0] data;
  logic [7:0] sh_q;
  logic [2:0] op;
  logic [1:0] shamt;
  logic [7:0] d_in;
  logic       busy;
  logic       done;
  logic [7:0] result;

  modport master (
    output start, mode, amount, data, sh_q,
    input  op, shamt, d_in, busy, done, result
  );

  modport slave (
    input  start, mode, amount, data, sh_q,
    output op, shamt, d_in, busy, done, result
  );
endinterface

// File: rtl/shift_seq8.sv
// Command sequencer for the 8-bit registered shifter: splits one 0..8 shift
// into LOAD plus steps of at most MAX_STEP bits and returns the shifter output.
module shift_seq8 #(
  parameter int MAX_STEP = 3
) (
  input  logic        clk,
  input  logic        reset,
  shift_seq8_if.slave bus
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b111;

  localparam logic [3:0] STEP_MAX  = 4'(MAX_STEP);
  localparam logic [3:0] TOTAL_MAX = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] data_q, data_d;
  logic [7:0] result_q, result_d;
  logic       done_q, done_d;

  logic [2:0] op_c;
  logic [1:0] shamt_c;
  logic [3:0] step_c;
  logic [3:0] rem_left_c;

  function automatic logic [3:0] clamp_total(input logic [3:0] amt);
    return (amt > TOTAL_MAX) ? TOTAL_MAX : amt;
  endfunction

  function automatic logic [3:0] step_of(input logic [3:0] rem);
    return (rem > STEP_MAX) ? STEP_MAX : rem;
  endfunction

  function automatic logic [2:0] shift_op(input logic [1:0] m);
    case (m)
      2'b00:   return OP_LSL;
      2'b01:   return OP_LSR;
      2'b10:   return OP_ASR;
      default: return OP_HOLD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= 4'd0;
      mode_q   <= 2'b00;
      data_q   <= 8'h00;
      result_q <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    data_d     = data_q;
    result_d   = result_q;
    done_d     = 1'b0;
    op_c       = OP_HOLD;
    shamt_c    = 2'b00;
    step_c     = 4'd0;
    rem_left_c = rem_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          data_d  = bus.data;
          // Pass-through is just a LOAD with no shift steps.
          rem_d   = (bus.mode == 2'b11) ? 4'd0 : clamp_total(bus.amount);
          state_d = LOAD;
        end
      end
      LOAD: begin
        op_c    = OP_LOAD;
        state_d = (rem_q != 4'd0) ? SHIFT : FIN;
      end
      SHIFT: begin
        op_c       = shift_op(mode_q);
        step_c     = step_of(rem_q);
        shamt_c    = step_c[1:0];
        rem_left_c = rem_q - step_c;
        rem_d      = rem_left_c;
        state_d    = (rem_left_c == 4'd0) ? FIN : SHIFT;
      end
      FIN: begin
        // Shifter register already holds the last step's value here.
        result_d = bus.sh_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.op     = op_c;
  assign bus.shamt  = shamt_c;
  assign bus.d_in   = data_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq8.sv
// Directed-vector bench for shift_seq8 with a behavioural shifter on the
// feedback path and a queue-based result scoreboard.
module tb_shift_seq8;

  logic clk;
  logic reset;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;

  shift_seq8_if bus ();

  shift_seq8 #(.MAX_STEP(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model of the downstream registered shifter.
  assign rst_n = ~reset;
  logic [7:0] sh_reg;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_reg <= 8'h00;
    else begin
      case (bus.op)
        3'b111:  sh_reg <= bus.d_in;
        3'b001:  sh_reg <= sh_reg << bus.shamt;
        3'b010:  sh_reg <= sh_reg >> bus.shamt;
        3'b100:  sh_reg <= 8'($signed(sh_reg) >>> bus.shamt);
        default: sh_reg <= sh_reg;
      endcase
    end
  end
  assign bus.sh_q = sh_reg;

  typedef struct {
    logic [7:0] res;
    int         at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: actual done=1 at cycle %0d required no pending request", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(bus.result), 32'(e.res));
        check("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic issue(input logic [7:0] d, input logic [1:0] m, input logic [3:0] a,
                       output int c0);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.data   = d;
    bus.mode   = m;
    bus.amount = a;
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.start = 1'b0;
  endtask

  // seq holds {op,shamt} per cycle after the start edge, first element in the low bits.
  task automatic req(input string name, input logic [7:0] d, input logic [1:0] m,
                     input logic [3:0] a, input logic [7:0] exp_r, input int lat,
                     input logic [24:0] seq);
    int   c0;
    exp_t e;
    issue(d, m, a, c0);
    e.res = exp_r;
    e.at  = c0 + lat;
    sb.push_back(e);
    for (int i = 0; i < lat; i++) begin
      check({name, "_opshamt"}, 32'({bus.op, bus.shamt}), 32'(seq[i*5 +: 5]));
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int c0;
    int guard;
    exp_t e;
    tests = 0;
    fails = 0;
    cyc   = 0;
    bus.start  = 1'b0;
    bus.data   = 8'h00;
    bus.mode   = 2'b00;
    bus.amount = 4'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_op", 32'(bus.op), 32'h0);
    check("rst_shamt", 32'(bus.shamt), 32'h0);
    check("rst_d_in", 32'(bus.d_in), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_result", 32'(bus.result), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    req("lsl2", 8'h0F, 2'b00, 4'd2, 8'h3C, 3, 25'({5'b000_00, 5'b001_10, 5'b111_00}));
    req("asr7", 8'h80, 2'b10, 4'd7, 8'hFF, 5,
        25'({5'b000_00, 5'b100_01, 5'b100_11, 5'b100_11, 5'b111_00}));
    req("lsr8", 8'hFF, 2'b01, 4'd8, 8'h00, 5,
        {5'b000_00, 5'b010_10, 5'b010_11, 5'b010_11, 5'b111_00});
    req("lsr12", 8'hFF, 2'b01, 4'd12, 8'h00, 5,
        {5'b000_00, 5'b010_10, 5'b010_11, 5'b010_11, 5'b111_00});
    req("amt0", 8'hA5, 2'b00, 4'd0, 8'hA5, 2, 25'({5'b000_00, 5'b111_00}));
    req("pass", 8'hA5, 2'b11, 4'd5, 8'hA5, 2, 25'({5'b000_00, 5'b111_00}));

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(8'h81, 2'b01, 4'd7, c0);
    e.res = 8'h01;
    e.at  = c0 + 5;
    sb.push_back(e);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.data   = 8'hFF;
    bus.mode   = 2'b11;
    bus.amount = 4'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_ignored", 32'(bus.busy), 32'h1);
    guard = 0;
    while (cyc != c0 + 5 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("reach_done_cycle", 32'(cyc), 32'(c0 + 5));
    bus.start  = 1'b1;
    bus.data   = 8'h0F;
    bus.mode   = 2'b00;
    bus.amount = 4'd2;
    e.res = 8'h3C;
    e.at  = c0 + 6 + 3;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_done_start", 32'(bus.busy), 32'h1);
    repeat (6) @(posedge clk);

    // Asynchronous reset in the middle of a long request.
    issue(8'h0F, 2'b00, 4'd8, c0);
    @(posedge clk);
    #3;
    check("pre_rst_op", 32'(bus.op), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_op", 32'(bus.op), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_done", 32'(bus.done), 32'h0);
    check("mid_rst_result", 32'(bus.result), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req("post_rst", 8'h0F, 2'b00, 4'd2, 8'h3C, 3, 25'({5'b000_00, 5'b001_10, 5'b111_00}));

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
